// File: rtl/fetch_unit_if.sv
// fetch_unit_if: redirect, instruction-memory and decode-side signals of the fetch unit
interface fetch_unit_if;
    logic        BrTaken;
    logic [63:0] branchVal;
    logic        stall;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [63:0] instr_addr;
    logic        instr_valid;
    modport master (
        input  BrTaken, branchVal, stall, imem_ack, imem_rdata,
        output imem_req, imem_addr, instruction, instr_addr, instr_valid
    );
    modport slave (
        output BrTaken, branchVal, stall, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instruction, instr_addr, instr_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with a 2-entry buffer and branch redirect
module fetch_unit (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {S_REQ, S_FULL, S_DRAIN} state_t;
    state_t      r_state, w_next;
    logic [63:0] r_pc, r_tgt;
    logic [63:0] r_addr [2];
    logic [31:0] r_data [2];
    logic        r_head;
    logic [1:0]  r_cnt;
    logic [63:0] w_tgt;
    logic        w_valid, w_out, w_push, w_pop, w_wr;
    assign w_tgt   = bus.branchVal & ~64'h3;
    assign w_valid = r_cnt != 2'd0;
    assign w_push  = r_state == S_REQ && bus.imem_ack && !bus.BrTaken;
    assign w_pop   = w_valid && !bus.stall && !bus.BrTaken;
    assign w_wr    = r_head ^ r_cnt[0];
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_REQ;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REQ:   w_next = bus.BrTaken ? (bus.imem_ack ? S_REQ : S_DRAIN) :
                              (w_push && !w_pop && r_cnt == 2'd1) ? S_FULL : S_REQ;
            S_FULL:  w_next = (bus.BrTaken || w_pop) ? S_REQ : S_FULL;
            S_DRAIN: w_next = bus.imem_ack ? S_REQ : S_DRAIN;
            default: w_next = S_REQ;
        endcase
    end
    always_comb begin
        w_out           = !reset && w_valid;
        bus.imem_req    = !reset && r_state != S_FULL;
        bus.imem_addr   = r_pc;
        bus.instr_valid = w_out;
        bus.instruction = w_out ? r_data[r_head] : 32'h0;
        bus.instr_addr  = w_out ? r_addr[r_head] : 64'h0;
    end
    // r_pc is the address of the in-flight request; a redirect behind it parks in r_tgt
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc   <= 64'h0;
            r_tgt  <= 64'h0;
            r_cnt  <= 2'd0;
            r_head <= 1'b0;
        end else if (bus.BrTaken) begin
            r_tgt  <= w_tgt;
            r_cnt  <= 2'd0;
            r_head <= 1'b0;
            if (r_state == S_FULL || bus.imem_ack) r_pc <= w_tgt;
        end else begin
            if (r_state == S_DRAIN && bus.imem_ack) r_pc <= r_tgt;
            else if (w_push)                         r_pc <= r_pc + 64'd4;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) r_head <= ~r_head;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[w_wr] <= r_pc;
            r_data[w_wr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a queue-based fetch model
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    fetch_unit_if bus ();
    fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct {
        logic [63:0] a;
        logic [31:0] d;
    } ent_t;
    ent_t        q[$];
    logic [63:0] m_pc = 64'h0;
    logic [63:0] m_tgt = 64'h0;
    bit          m_drain = 1'b0;
    int          checks = 0;
    int          errors = 0;
    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // the model: a request is outstanding while draining or while the buffer has room
    task automatic step(bit rst, bit br, logic [63:0] bv, bit st, bit ack);
        bit          req_e, val_e, pop;
        logic [31:0] rd;
        ent_t        e;
        rd = $urandom;
        reset = rst; bus.BrTaken = br; bus.branchVal = bv;
        bus.stall = st; bus.imem_ack = ack; bus.imem_rdata = rd;
        #1;
        req_e = !rst && (m_drain || q.size() < 2);
        val_e = !rst && q.size() > 0;
        chk("imem_req", bus.imem_req, req_e);
        if (req_e) chk("imem_addr", bus.imem_addr, m_pc);
        chk("instr_valid", bus.instr_valid, val_e);
        chk("instruction", bus.instruction, val_e ? q[0].d : 32'h0);
        chk("instr_addr", bus.instr_addr, val_e ? q[0].a : 64'h0);
        @(posedge clk);
        if (rst) begin
            q.delete(); m_pc = 64'h0; m_drain = 1'b0;
        end else if (br) begin
            q.delete();
            if (req_e && !ack) begin
                m_drain = 1'b1; m_tgt = {bv[63:2], 2'b00};
            end else begin
                m_drain = 1'b0; m_pc = {bv[63:2], 2'b00};
            end
        end else begin
            pop = val_e && !st;
            if (pop) void'(q.pop_front());
            if (req_e && ack) begin
                if (m_drain) begin
                    m_drain = 1'b0; m_pc = m_tgt;
                end else begin
                    e.a = m_pc; e.d = rd; q.push_back(e); m_pc = m_pc + 64'd4;
                end
            end
        end
        @(negedge clk);
    endtask
    initial begin
        reset = 1'b1; bus.BrTaken = 1'b0; bus.branchVal = 64'h0;
        bus.stall = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        @(negedge clk);
        step(1, 0, 0, 0, 1); step(1, 1, 64'h55, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
        chk("stall_req_low", bus.imem_req, 1'b0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
        step(0, 1, 64'h103, 0, 0);
        chk("drain_holds_8", bus.imem_addr, 64'h8);
        step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        chk("drain_still_8", bus.imem_addr, 64'h8);
        step(0, 0, 0, 0, 1);
        chk("redirect_100", bus.imem_addr, 64'h100);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        chk("at_12", bus.imem_addr, 64'hc);
        step(0, 1, 64'h40, 0, 1);
        chk("redirect_40", bus.imem_addr, 64'h40);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 1, 64'h10, 0, 0); step(0, 1, 64'h200, 0, 0); step(0, 1, 64'h300, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("latest_wins", bus.imem_addr, 64'h300);
        step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 0);
        step(1, 1, 64'h80, 0, 1);
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_req", bus.imem_req, 1'b0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++)
            step($urandom_range(63) == 0, $urandom_range(7) == 0, {$urandom, $urandom},
                 $urandom_range(2) == 0, $urandom_range(1) == 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
